// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic ready/valid pipeline register with one skid entry.
//
// The main register always holds the head entry and drives out_data directly.
// A second (skid) register absorbs the one extra word that can arrive while the
// head is stalled. Because of it, in_ready can be decoded purely from the state
// flops, with no combinational path from out_ready. Full-rate streaming is kept.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (state EMPTY, data = RESET_VAL)
//   flush      synchronous squash of all held entries
//   in_valid   upstream presents in_data
//   in_ready   block can accept (function of state flops only)
//   in_data    upstream data, sampled only on accept
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts
//   out_data   head entry, driven from the main register
//   count      occupancy 0..2
module pipe_skid_reg #(
  parameter int unsigned    N         = 32,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  // Encoding equals occupancy so count is a direct view of the state register.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         accept, pop;

  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign count     = state_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers are left alone; out_data is don't-care while invalid.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = StTwo;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline register: a ready/valid successor to the plain and clock-enable register primitives, used between core pipeline stages and on memory/IO paths.
- Holds a main register plus one skid entry, so input ready is a pure flop output with no combinational path from out_ready.
- Sustains one transfer per cycle.
- Adds a synchronous flush for branch/trap squash, plus a programmable reset value.

Parameters:
N, 32, data width in bits (N >= 1)
RESET_VAL, {N{1'b0}}, value loaded into both data registers on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous squash: discard all held entries
in_valid  input  1  upstream presents in_data
in_ready  output  1  block can accept; registered, depends only on state
in_data  input  N  upstream data
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts
out_data  output  N  head entry; driven from the main register only
count  output  2  occupancy, 0..2

Behaviour:
- Definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated at the rising edge of clk.
- Reset (asynchronous, rst=1), immediately and for as long as rst is held:
  - state=EMPTY, count=0, out_valid=0, in_ready=1.
  - Main and skid data registers = RESET_VAL, so out_data=RESET_VAL.
  - Reset mid-transfer drops all entries; no partial update.
- States:
  - EMPTY (count 0): out_valid=0, in_ready=1.
  - ONE (count 1): main valid; out_valid=1, in_ready=1.
  - TWO (count 2): main and skid valid; out_valid=1, in_ready=0.
- Transitions (flush=0):
  - EMPTY + accept -> ONE; main<=in_data.
  - EMPTY without accept -> EMPTY.
  - ONE + accept & pop -> ONE; main<=in_data (back-to-back streaming).
  - ONE + accept & !pop -> TWO; skid<=in_data; main unchanged.
  - ONE + !accept & pop -> EMPTY.
  - ONE + neither -> ONE; all held.
  - TWO + pop -> ONE; main<=skid. accept is impossible because in_ready=0.
  - TWO + !pop -> TWO; all held.
- Latency:
  - Data accepted at edge k appears on out_data with out_valid=1 after edge k, when the block was EMPTY, or after main was popped when it was ONE.
  - No combinational in->out path.
- Ordering: strict FIFO; the skid entry never overtakes main.
- Flush:
  - Highest priority below rst.
  - At the edge: state -> EMPTY, count -> 0.
  - Any accept or pop in that same cycle is ignored. The upstream handshake did complete, but the datum is discarded.
  - Data registers are not cleared (out_data is don't-care while out_valid=0).
- Stability (AXI-style):
  - While out_valid=1 and out_ready=0, out_data and out_valid are held constant.
  - out_valid never deasserts without a pop or flush.
- out_data after the last pop retains its last value; consumers must qualify it with out_valid.
- count equals the number of valid entries in every state.
- X handling: in_data is sampled only on accept; X on in_data with in_valid=0 must not propagate.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, count=0, out_data=RESET_VAL. Then assert rst asynchronously mid-cycle while in ONE -> out_valid drops before the next edge.
- Single transfer: in_data=32'hdeadbeef, in_valid=1 for one cycle, out_ready=0 -> after the edge out_valid=1, out_data=deadbeef, count=1. Hold 3 cycles -> data stable. Then out_ready=1 -> pop, count=0.
- Backpressure fill: out_ready=0, send deadbeef then cafebabe -> count=2, in_ready=0, out_data=deadbeef. Then out_ready=1 -> out_data=cafebabe next cycle, count=1, in_ready=1.
- Full throughput: out_ready=1, stream 16 words 0..15 with in_valid=1 every cycle -> in_ready stays 1, outputs 0..15 in order, one per cycle, 1-cycle latency.
- Flush: in TWO (deadbeef, cafebabe), assert flush with in_valid=1 (in_ready=0) and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; neither word is ever popped. Repeat from ONE with accept in the flush cycle -> the accepted word is discarded.
- Random: 10k cycles of random in_valid, out_ready and flush against a queue model -> order, count and stability rules hold; out_valid/in_ready never both 0 in ONE.
